ice_fm_tx_param: RTL



---
 rtl/ice_fm_tx_param.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ice_fm_tx_param.sv
// FM transmitter core: nibble command decoder, sample memory, phase accumulator and memory dump.
// Define ICE_FM_TX_PARAM_STATUS_EN to enable the 0xE status byte command.
module ice_fm_tx_param #(
  parameter int ACC_W      = 24,
  parameter int SAMPLE_W   = 16,
  parameter int DEPTH_LOG2 = 6,
  parameter int DIV_W      = 16,
  parameter int DEV_SHIFT  = 4
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_fm
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NIB   = SAMPLE_W / 4;
  localparam int NC_W  = $clog2(NIB);
  localparam int BPE   = SAMPLE_W / 8;
  localparam int BI_W  = (BPE > 1) ? $clog2(BPE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_SEND, S_STAT} state_t;

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d, car_q, car_d, car_sh_q, car_sh_d;
  logic [DIV_W-1:0]      div_q, div_d, div_sh_q, div_sh_d, tcnt_q, tcnt_d;
  logic [SAMPLE_W-1:0]   samp_sh_q, samp_sh_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d, addr_q, addr_d;
  logic [NC_W-1:0]       ncnt_q, ncnt_d;
  logic [BI_W-1:0]       bidx_q, bidx_d;
  logic [7:0]            stat_q, stat_d;
  logic                  run_q, run_d, fm_q, fm_d;

  logic [SAMPLE_W-1:0]   mem [DEPTH];
  logic [SAMPLE_W-1:0]   samp_q, dump_q, mem_wdata;
  logic                  mem_we;
  logic [ACC_W-1:0]      dev;
  logic [3:0]            op, nib;
  logic                  cmd_go;

  assign op     = i_rx_data[3:0];
  assign nib    = i_rx_data[7:4];
  assign cmd_go = i_rx_valid && (state_q == S_IDLE);
  assign dev    = ACC_W'($signed(samp_q)) << DEV_SHIFT;

  // Modulation first so that commands in the same cycle take priority.
  always_comb begin
    acc_d     = acc_q;
    car_d     = car_q;
    car_sh_d  = car_sh_q;
    div_d     = div_q;
    div_sh_d  = div_sh_q;
    tcnt_d    = tcnt_q;
    samp_sh_d = samp_sh_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ncnt_d    = ncnt_q;
    run_d     = run_q;
    fm_d      = run_q & acc_q[ACC_W-1];
    mem_we    = 1'b0;
    mem_wdata = {nib, samp_sh_q[SAMPLE_W-1:4]};
    if (run_q) begin
      acc_d = acc_q + car_q + dev;
      if (tcnt_q == div_q) begin
        tcnt_d = '0;
        rptr_d = rptr_q + DEPTH_LOG2'(1);
      end else begin
        tcnt_d = tcnt_q + DIV_W'(1);
      end
    end
    if (cmd_go) begin
      case (op)
        4'h0: begin
          wptr_d    = '0;
          rptr_d    = '0;
          ncnt_d    = '0;
          samp_sh_d = '0;
        end
        4'h1: begin
          samp_sh_d = mem_wdata;
          if (ncnt_q == NC_W'(NIB - 1)) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + DEPTH_LOG2'(1);
            ncnt_d = '0;
          end else begin
            ncnt_d = ncnt_q + NC_W'(1);
          end
        end
        4'h2: div_sh_d = {nib, div_sh_q[DIV_W-1:4]};
        4'h3: begin
          div_d  = div_sh_q;
          tcnt_d = '0;
        end
        4'h4: car_sh_d = {nib, car_sh_q[ACC_W-1:4]};
        4'h5: car_d    = car_sh_q;
        4'h6: run_d    = i_rx_data[4];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bidx_d     = bidx_q;
    stat_d     = stat_q;
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_go && op == 4'hF) begin
          addr_d  = '0;
          state_d = S_RD;
        end
`ifdef ICE_FM_TX_PARAM_STATUS_EN
        if (cmd_go && op == 4'hE) begin
          stat_d  = {run_q, 7'(wptr_q)};
          state_d = S_STAT;
        end
`endif
      end
      S_RD: begin
        bidx_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'(dump_q >> (8 * bidx_q));
        if (i_tx_ready) begin
          if (bidx_q == BI_W'(BPE - 1)) begin
            if (addr_q == '1) begin
              state_d = S_IDLE;
            end else begin
              addr_d  = addr_q + DEPTH_LOG2'(1);
              state_d = S_RD;
            end
          end else begin
            bidx_d = bidx_q + BI_W'(1);
          end
        end
      end
      S_STAT: begin
        o_tx_valid = 1'b1;
        o_tx_data  = stat_q;
        if (i_tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy = (state_q != S_IDLE);
  assign o_fm   = fm_q;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      car_q     <= '0;
      car_sh_q  <= '0;
      div_q     <= '0;
      div_sh_q  <= '0;
      tcnt_q    <= '0;
      samp_sh_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      addr_q    <= '0;
      ncnt_q    <= '0;
      bidx_q    <= '0;
      stat_q    <= '0;
      run_q     <= 1'b0;
      fm_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      car_q     <= car_d;
      car_sh_q  <= car_sh_d;
      div_q     <= div_d;
      div_sh_q  <= div_sh_d;
      tcnt_q    <= tcnt_d;
      samp_sh_q <= samp_sh_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      addr_q    <= addr_d;
      ncnt_q    <= ncnt_d;
      bidx_q    <= bidx_d;
      stat_q    <= stat_d;
      run_q     <= run_d;
      fm_q      <= fm_d;
    end
  end

  // Reading the next pointer lets a new sample reach the accumulator one cycle after its tick.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wptr_q] <= mem_wdata;
    samp_q <= mem[rptr_d];
    if (state_q == S_RD) dump_q <= mem[addr_q];
  end

endmodule
